rom_stream_sequencer: RTL and testbench
=======================================

// Module: rom_stream_sequencer
// PURPOSE
//  Address generator and output stage for a combinational lookup ROM (2-bit addr -> 4-bit data, 3 entries).
//  - Walks addresses 0..DEPTH-1 and drives them to the ROM's io_addr.
//  - Captures the returned word into a registered valid/ready output stream, one word per cycle when unstalled.
//  - Supports one-shot, continuous-loop and abort operation.
//  - Sits directly upstream of the ROM; the parent instantiates both side by side.
// PARAMETERS
//  ADDR_W   2   ROM address width
//  DATA_W   4   ROM data width
//  DEPTH    3   populated ROM entries; addresses >= DEPTH must never be driven
//  COUNT_W  8   width of delivered-word counter
// PORTS
//  clk           in   1        single clock, rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  io_start      in   1        begin a pass; honoured only in IDLE
//  io_loop       in   1        sampled with io_start: 1 = wrap and repeat until io_stop
//  io_stop       in   1        abort request; honoured in RUN
//  io_rom_addr   out  ADDR_W   to ROM io_addr
//  io_rom_data   in   DATA_W   from ROM io_out, same cycle
//  io_out_valid  out  1        output word valid
//  io_out_ready  in   1        consumer accepts word
//  io_out_bits   out  DATA_W   registered ROM word
//  io_out_last   out  1        word came from address DEPTH-1
//  io_busy       out  1        state != IDLE
//  io_done       out  1        one-cycle pulse when a pass or abort completes
//  io_count      out  COUNT_W  words accepted since reset; wraps modulo 2^COUNT_W
// BEHAVIOUR
//  Reset state (async, all registers)
//  - state=IDLE, addr_q=0, loop_q=0.
//  - out_valid=0, out_bits=0, out_last=0, done=0, count=0.
//  - Reset mid-pass discards the held word immediately.
//  ROM address
//  - io_rom_addr = addr_q in RUN; 0 in IDLE and DRAIN.
//  - addr_q is never >= DEPTH.
//  Output register
//  - load = (state==RUN) && !io_stop && (!out_valid || io_out_ready).
//  - On load: out_bits<=io_rom_data; out_last<=(addr_q==DEPTH-1); out_valid<=1.
//  - addr_q <= (addr_q==DEPTH-1) ? 0 : addr_q+1.
//  - out_valid clears only on handshake without a concurrent load.
//  - out_bits/out_last are stable while valid && !ready.
//  - count increments on every handshake (out_valid && io_out_ready).
//  FSM
//  - IDLE : io_start -> RUN; addr_q<=0; loop_q<=io_loop. Other inputs ignored.
//  - RUN  : load && addr_q==DEPTH-1 && !loop_q -> DRAIN.
//           io_stop -> DRAIN; no load that cycle; the held word stays and keeps its last flag.
//           io_start is ignored.
//  - DRAIN: (!out_valid) or (out_valid && io_out_ready) -> IDLE with done pulse in the same cycle as the transition.
//           out_valid clears on that handshake.
//  Latency and throughput
//  - io_start at cycle N -> first io_out_valid at N+2.
//  - With ready held at 1: one word per cycle, no bubbles, including across loop wrap.
//  Boundary cases
//  - Stall: no address advance and no ROM sample while valid && !ready.
//  - Start while busy: ignored; no restart.
//  - Stop while out_valid=0: done one cycle later.
//  - io_done is registered and high for exactly one cycle.
// STRUCTURE
//  - Package rom_seq_pkg:
//    - state enum {IDLE=2'd0, RUN=2'd1, DRAIN=2'd2}
//    - default ADDR_W/DATA_W/DEPTH constants
//  - Single flat module; no sub-module. The wrap counter is too small to split out.
//  - The ROM is not instantiated here.
//  - Simulation-only assertion: io_rom_addr < DEPTH whenever state==RUN. Out-of-range addresses return $random.
// TESTING  (DEPTH=3, ROM = {0:4'h1, 1:4'h2, 2:4'h3})
//  1. One-shot: start, loop=0, ready=1.
//     -> bits 1,2,3 on cycles N+2..N+4; last=1 only on 3; done at N+5; busy low after; count=3.
//  2. Backpressure: ready toggles 1,0,0,1,...
//     -> bits stay stable while stalled; sequence still 1,2,3 with no drop or duplicate.
//  3. Loop: start with loop=1, ready=1, 7 cycles, then stop.
//     -> 1,2,3,1,2,3,1 ...; last=1 on every 3; done after drain; count=number of accepted words.
//  4. Stop while stalled: ready=0 holding word 2, assert stop.
//     -> word 2 remains valid; next ready=1 accepts it; done that cycle; no word 3.
//  5. Start ignored: pulse start during RUN -> sequence unaffected; addr never restarts at 0 mid-pass.
//  6. Async reset: assert reset_n=0 mid-pass between clock edges.
//     -> valid, busy and done are 0 immediately; count=0; next start yields 1,2,3.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// rtl/rom_seq_pkg.sv - shared types and default sizes for the ROM stream sequencer
//
// Purpose : sequencer state encoding and default ROM geometry.
// Contents: state_t       - IDLE / RUN / DRAIN
//           ROM_ADDR_W    - default ROM address width
//           ROM_DATA_W    - default ROM data width
//           ROM_DEPTH     - default number of populated ROM entries
//           SEQ_COUNT_W   - default width of the delivered-word counter
package rom_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int ROM_ADDR_W  = 2;
  localparam int ROM_DATA_W  = 4;
  localparam int ROM_DEPTH   = 3;
  localparam int SEQ_COUNT_W = 8;

endpackage

// File: rtl/rom_stream_sequencer.sv
// rtl/rom_stream_sequencer.sv - address walker and registered output stage for a combinational ROM
//
// Purpose : walks ROM addresses 0..DEPTH-1, captures each returned word into a
//           registered valid/ready stream. Supports one-shot, looping and abort.
// Ports   : clk           in   rising-edge clock
//           reset_n       in   asynchronous active-low reset
//           io_start      in   begin a pass (IDLE only)
//           io_loop       in   sampled with io_start; 1 = repeat until io_stop
//           io_stop       in   abort request (RUN only)
//           io_rom_addr   out  ROM address (addr_q in RUN, else 0)
//           io_rom_data   in   ROM word for io_rom_addr, same cycle
//           io_out_valid  out  output word valid
//           io_out_ready  in   consumer accepts word
//           io_out_bits   out  registered ROM word
//           io_out_last   out  word came from address DEPTH-1
//           io_busy       out  state != IDLE
//           io_done       out  one-cycle pulse when a pass or abort completes
//           io_count      out  accepted words since reset, wraps
module rom_stream_sequencer
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W,
  parameter int DEPTH   = ROM_DEPTH,
  parameter int COUNT_W = SEQ_COUNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               io_start,
  input  logic               io_loop,
  input  logic               io_stop,
  output logic [ADDR_W-1:0]  io_rom_addr,
  input  logic [DATA_W-1:0]  io_rom_data,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [DATA_W-1:0]  io_out_bits,
  output logic               io_out_last,
  output logic               io_busy,
  output logic               io_done,
  output logic [COUNT_W-1:0] io_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                loop_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_bits_q;
  logic                out_last_q;
  logic                done_q;
  logic [COUNT_W-1:0]  count_q;

  logic handshake;
  logic load;
  logic at_last;

  assign handshake = out_valid_q && io_out_ready;
  // A word is captured only while running, not aborting, and the output
  // register is empty or being emptied this cycle (keeps full throughput).
  assign load      = (state_q == RUN) && !io_stop && (!out_valid_q || io_out_ready);
  assign at_last   = (addr_q == LAST_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      loop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      done_q <= 1'b0;

      if (handshake) begin
        count_q <= count_q + COUNT_W'(1);
      end

      if (load) begin
        out_bits_q  <= io_rom_data;
        out_last_q  <= at_last;
        out_valid_q <= 1'b1;
        addr_q      <= at_last ? '0 : addr_q + ADDR_W'(1);
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (io_start) begin
            state_q <= RUN;
            addr_q  <= '0;
            loop_q  <= io_loop;
          end
        end
        RUN: begin
          // Abort keeps whatever word is held; DRAIN delivers it.
          if (io_stop) begin
            state_q <= DRAIN;
          end else if (load && at_last && !loop_q) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid_q || io_out_ready) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io_rom_addr  = (state_q == RUN) ? addr_q : '0;
  assign io_out_valid = out_valid_q;
  assign io_out_bits  = out_bits_q;
  assign io_out_last  = out_last_q;
  assign io_busy      = (state_q != IDLE);
  assign io_done      = done_q;
  assign io_count     = count_q;

  // Unpopulated ROM entries return garbage, so they must never be addressed.
  a_addr_in_range : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == RUN) |-> ({1'b0, io_rom_addr} < (ADDR_W + 1)'(DEPTH)));

  a_done_single : assert property (@(posedge clk) disable iff (!reset_n)
    done_q |=> !done_q);

endmodule

// File: tb/tb_rom_stream_sequencer.sv
// tb/tb_rom_stream_sequencer.sv - self-checking bench for rom_stream_sequencer
module tb_rom_stream_sequencer;
  import rom_seq_pkg::*;

  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       io_start, io_loop, io_stop, io_out_ready;
  logic [1:0] io_rom_addr;
  logic [3:0] io_rom_data;
  logic       io_out_valid, io_out_last, io_busy, io_done;
  logic [3:0] io_out_bits;
  logic [7:0] io_count;

  always #5 clk = ~clk;

  rom_stream_sequencer #(.ADDR_W(2), .DATA_W(4), .DEPTH(DEPTH), .COUNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .io_start(io_start), .io_loop(io_loop), .io_stop(io_stop),
    .io_rom_addr(io_rom_addr), .io_rom_data(io_rom_data), .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready), .io_out_bits(io_out_bits), .io_out_last(io_out_last),
    .io_busy(io_busy), .io_done(io_done), .io_count(io_count)
  );

  logic [3:0] rom_tab [DEPTH] = '{4'h1, 4'h2, 4'h3};

  // ROM behaviour: populated entries fixed, anything else random.
  always @* begin
    if (int'(io_rom_addr) < DEPTH) io_rom_data = rom_tab[io_rom_addr];
    else                           io_rom_data = 4'($urandom);
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Observation state collected once per cycle.
  logic [4:0] got_q[$];
  int         hs_total, done_cnt, stall_bad, addr_bad;
  logic       prev_stall;
  logic [3:0] prev_bits;
  logic       prev_last;
  logic       s_valid, s_last, s_done, s_busy;
  logic [3:0] s_bits;

  task automatic clear_obs();
    got_q.delete();
    done_cnt   = 0;
    stall_bad  = 0;
    prev_stall = 1'b0;
  endtask

  // Sample the current cycle at the falling edge, then move to just past the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_valid = io_out_valid; s_bits = io_out_bits; s_last = io_out_last;
    s_done  = io_done;      s_busy = io_busy;
    if (prev_stall && (!io_out_valid || io_out_bits !== prev_bits || io_out_last !== prev_last))
      stall_bad++;
    prev_stall = io_out_valid && !io_out_ready;
    prev_bits  = io_out_bits;
    prev_last  = io_out_last;
    if (io_out_valid && io_out_ready) begin
      got_q.push_back({io_out_last, io_out_bits});
      hs_total++;
    end
    if (io_done) done_cnt++;
    if (io_busy && int'(io_rom_addr) >= DEPTH) addr_bad++;
    @(posedge clk); #1;
  endtask

  function automatic logic [4:0] model_word(int k);
    return {(k % DEPTH) == DEPTH - 1, rom_tab[k % DEPTH]};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; io_start = 0; io_loop = 0; io_stop = 0; io_out_ready = 0;
    hs_total = 0; addr_bad = 0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (io_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", io_out_valid); end
    n_cmp++; if (io_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", io_busy); end
    n_cmp++; if (io_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", io_done); end
    n_cmp++; if (io_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", io_count); end
    n_cmp++; if ({io_out_last, io_out_bits} !== 5'd0) begin n_bad++; $display("FAIL reset_bits got=%h exp=0", {io_out_last, io_out_bits}); end
    n_cmp++; if (io_rom_addr !== 2'd0) begin n_bad++; $display("FAIL reset_addr got=%0d exp=0", io_rom_addr); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_one_shot();
    logic exp_valid;
    clear_obs();
    io_loop = 0; io_out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      io_start = (k == 0);
      tick();
      exp_valid = (k >= 2 && k <= 4);
      n_cmp++; if (s_valid !== exp_valid) begin n_bad++; $display("FAIL one_shot_valid k=%0d got=%b exp=%b", k, s_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++; if (s_bits !== rom_tab[k-2]) begin n_bad++; $display("FAIL one_shot_bits k=%0d got=%h exp=%h", k, s_bits, rom_tab[k-2]); end
        n_cmp++; if (s_last !== (k == 4)) begin n_bad++; $display("FAIL one_shot_last k=%0d got=%b exp=%b", k, s_last, k == 4); end
      end
      n_cmp++; if (s_done !== (k == 5)) begin n_bad++; $display("FAIL one_shot_done k=%0d got=%b exp=%b", k, s_done, k == 5); end
      n_cmp++; if (s_busy !== (k >= 1 && k <= 4)) begin n_bad++; $display("FAIL one_shot_busy k=%0d got=%b exp=%b", k, s_busy, (k >= 1 && k <= 4)); end
    end
    n_cmp++; if (io_count !== 8'd3) begin n_bad++; $display("FAIL one_shot_count got=%0d exp=3", io_count); end
  endtask

  task automatic test_backpressure();
    int pat[4] = '{1, 0, 0, 1};
    clear_obs();
    io_loop = 0;
    for (int k = 0; k < 40 && done_cnt == 0; k++) begin
      io_start = (k == 0);
      io_out_ready = pat[k % 4][0];
      tick();
    end
    io_out_ready = 1;
    repeat (3) tick();
    n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL bp_len got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== model_word(i)) begin n_bad++; $display("FAIL bp_word i=%0d got=%h exp=%h", i, got_q[i], model_word(i)); end
    end
    n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", stall_bad); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done got=%0d pulses exp=1", done_cnt); end
    n_cmp++; if (io_count !== 8'(hs_total)) begin n_bad++; $display("FAIL bp_count got=%0d exp=%0d", io_count, 8'(hs_total)); end
  endtask

  task automatic test_loop();
    int done_k = -1;
    clear_obs();
    io_loop = 1; io_out_ready = 1;
    for (int k = 0; k < 20 && done_k < 0; k++) begin
      io_start = (k == 0);
      io_stop  = (k == 8);
      tick();
      if (s_done) done_k = k;
    end
    io_stop = 0; io_loop = 0;
    n_cmp++; if (got_q.size() !== 7) begin n_bad++; $display("FAIL loop_len got=%0d exp=7", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== model_word(i)) begin n_bad++; $display("FAIL loop_word i=%0d got=%h exp=%h", i, got_q[i], model_word(i)); end
    end
    n_cmp++; if (done_k !== 10) begin n_bad++; $display("FAIL loop_done_cycle got=%0d exp=10", done_k); end
    n_cmp++; if (io_count !== 8'(hs_total)) begin n_bad++; $display("FAIL loop_count got=%0d exp=%0d", io_count, 8'(hs_total)); end
  endtask

  task automatic test_random_loop();
    for (int it = 0; it < 4; it++) begin
      int run_len = $urandom_range(6, 30);
      clear_obs();
      io_loop = 1;
      for (int k = 0; k <= run_len; k++) begin
        io_start = (k == 0);
        io_out_ready = 1'($urandom);
        tick();
      end
      io_start = 0; io_loop = 0;
      io_stop = 1; io_out_ready = 1'($urandom);
      tick();
      io_stop = 0;
      for (int k = 0; k < 60 && done_cnt == 0; k++) begin
        io_out_ready = 1'($urandom);
        tick();
      end
      io_out_ready = 1;
      tick();
      for (int i = 0; i < got_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== model_word(i)) begin n_bad++; $display("FAIL rnd_word it=%0d i=%0d got=%h exp=%h", it, i, got_q[i], model_word(i)); end
      end
      n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL rnd_stable it=%0d got=%0d exp=0", it, stall_bad); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rnd_done it=%0d got=%0d exp=1", it, done_cnt); end
      n_cmp++; if (io_busy !== 1'b0) begin n_bad++; $display("FAIL rnd_idle it=%0d got=%b exp=0", it, io_busy); end
      n_cmp++; if (io_count !== 8'(hs_total)) begin n_bad++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, io_count, 8'(hs_total)); end
    end
  endtask

  task automatic test_stop_stalled();
    int rdy[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    clear_obs();
    io_loop = 0;
    for (int k = 0; k < 8; k++) begin
      io_start = (k == 0);
      io_stop  = (k == 3);
      io_out_ready = rdy[k][0];
      tick();
      if (k == 3 || k == 4) begin
        n_cmp++; if ({s_valid, s_last, s_bits} !== {2'b10, rom_tab[1]}) begin n_bad++; $display("FAIL stop_hold k=%0d got=%h exp=%h", k, {s_valid, s_last, s_bits}, {2'b10, rom_tab[1]}); end
      end
      n_cmp++; if (s_done !== (k == 6)) begin n_bad++; $display("FAIL stop_done k=%0d got=%b exp=%b", k, s_done, k == 6); end
      if (k == 7) begin
        n_cmp++; if ({s_valid, s_busy} !== 2'b00) begin n_bad++; $display("FAIL stop_idle got=%b exp=00", {s_valid, s_busy}); end
      end
    end
    io_stop = 0;
    repeat (3) tick();
    n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL stop_len got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== model_word(i)) begin n_bad++; $display("FAIL stop_word i=%0d got=%h exp=%h", i, got_q[i], model_word(i)); end
    end
  endtask

  task automatic test_start_ignored();
    clear_obs();
    io_loop = 0; io_out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      io_start = (k == 0 || k == 2 || k == 3);
      io_loop  = (k != 0);
      tick();
    end
    io_start = 0; io_loop = 0;
    n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL ign_len got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== model_word(i)) begin n_bad++; $display("FAIL ign_word i=%0d got=%h exp=%h", i, got_q[i], model_word(i)); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ign_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_async_reset();
    clear_obs();
    io_loop = 0; io_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      io_start = (k == 0);
      tick();
    end
    io_start = 0;
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({io_out_valid, io_busy, io_done} !== 3'b000) begin n_bad++; $display("FAIL areset_flags got=%b exp=000", {io_out_valid, io_busy, io_done}); end
    n_cmp++; if (io_count !== 8'd0) begin n_bad++; $display("FAIL areset_count got=%0d exp=0", io_count); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    hs_total = 0;
    clear_obs();
    for (int k = 0; k < 10; k++) begin
      io_start = (k == 0);
      tick();
    end
    io_start = 0;
    n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL areset_len got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== model_word(i)) begin n_bad++; $display("FAIL areset_word i=%0d got=%h exp=%h", i, got_q[i], model_word(i)); end
    end
    n_cmp++; if (io_count !== 8'd3) begin n_bad++; $display("FAIL areset_recount got=%0d exp=3", io_count); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_backpressure();
    test_loop();
    test_random_loop();
    test_stop_stalled();
    test_start_ignored();
    test_async_reset();
    n_cmp++; if (addr_bad !== 0) begin n_bad++; $display("FAIL addr_range got=%0d out-of-range cycles exp=0", addr_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
